// File: rtl/poly_decompress_ctrl.sv
// rtl/poly_decompress_ctrl.sv - unpacks D-bit fields from a byte stream and decompresses them to 12-bit coefficients
// Optional stall counter port enabled by DECOMP_STALL_CNT_EN.
module poly_decompress_ctrl #(
  parameter int N_COEFF = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  d_sel,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] coeff,
  output logic [7:0]  coeff_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
`ifdef DECOMP_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic        err
);

  localparam logic [9:0] NB8      = 10'(N_COEFF / 8);
  localparam logic [7:0] LAST_IDX = 8'(N_COEFF - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic [23:0] bit_buf, buf_shift, buf_next;
  logic [4:0]  bit_cnt, cnt_after, cnt_next;
  logic [9:0]  bytes_taken, total_bytes;
  logic [3:0]  d_reg, d_dec;
  logic        start_ok, accept, extract, out_hs;
  logic [10:0] y;
  logic [23:0] prod;
  logic [11:0] coeff_calc;

  always_comb begin
    d_dec = 4'd0;
    case (d_sel)
      3'd0:    d_dec = 4'd1;
      3'd1:    d_dec = 4'd4;
      3'd2:    d_dec = 4'd5;
      3'd3:    d_dec = 4'd10;
      3'd4:    d_dec = 4'd11;
      default: d_dec = 4'd0;
    endcase
  end

  assign start_ok    = start && (d_sel <= 3'd4);
  assign total_bytes = NB8 * {6'd0, d_reg};
  assign in_ready    = (state == RUN) && (bit_cnt <= 5'd16) && (bytes_taken < total_bytes);
  assign accept      = in_valid && in_ready;
  assign out_hs      = out_valid && out_ready;
  assign extract     = (state == RUN) && (bit_cnt >= {1'b0, d_reg}) && (!out_valid || out_ready);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // Shift out the extracted field first, then append the new byte above what remains.
  always_comb begin
    buf_shift = extract ? (bit_buf >> d_reg) : bit_buf;
    cnt_after = extract ? (bit_cnt - {1'b0, d_reg}) : bit_cnt;
    buf_next  = accept ? (buf_shift | ({16'd0, in_data} << cnt_after)) : buf_shift;
    cnt_next  = accept ? (cnt_after + 5'd8) : cnt_after;
  end

  // Rounded y*q/2^D; the 24-bit product holds 2047*3329 plus rounding without loss.
  always_comb begin
    y          = 11'(bit_buf & ((24'd1 << d_reg) - 24'd1));
    prod       = {13'd0, y} * 24'd3329 + (24'd1 << (d_reg - 4'd1));
    coeff_calc = 12'(prod >> d_reg);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (out_hs && (coeff_idx == LAST_IDX)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_buf     <= 24'd0;
      bit_cnt     <= 5'd0;
      bytes_taken <= 10'd0;
      coeff_idx   <= 8'd0;
      coeff       <= 12'd0;
      out_valid   <= 1'b0;
      err         <= 1'b0;
      d_reg       <= 4'd0;
    end else begin
      err <= (state == IDLE) && start && (d_sel > 3'd4);
      if ((state == IDLE) && start_ok) begin
        d_reg       <= d_dec;
        bit_buf     <= 24'd0;
        bit_cnt     <= 5'd0;
        bytes_taken <= 10'd0;
        coeff_idx   <= 8'd0;
        out_valid   <= 1'b0;
      end else begin
        bit_buf <= buf_next;
        bit_cnt <= cnt_next;
        if (accept) bytes_taken <= bytes_taken + 10'd1;
        if (extract) begin
          coeff     <= coeff_calc;
          out_valid <= 1'b1;
        end else if (out_hs) begin
          out_valid <= 1'b0;
        end
        if (out_hs) coeff_idx <= coeff_idx + 8'd1;
      end
    end
  end

`ifdef DECOMP_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= 16'd0;
    else if ((state == IDLE) && start_ok)
      stall_cnt <= 16'd0;
    else if ((state == RUN) && out_valid && !out_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_poly_decompress_ctrl.sv
// tb/tb_poly_decompress_ctrl.sv - randomized scoreboard bench for poly_decompress_ctrl
`timescale 1ns/1ps
module tb_poly_decompress_ctrl;
  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  d_sel = 3'd0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] coeff;
  logic [7:0]  coeff_idx;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done, err;
`ifdef DECOMP_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  poly_decompress_ctrl #(.N_COEFF(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d_sel(d_sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coeff(coeff), .coeff_idx(coeff_idx), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done),
`ifdef DECOMP_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [7:0] byte_q[$];
  int exp_coeff[$], exp_idx[$];
  int bytes_acc = 0, done_cnt = 0, err_cnt = 0;
  int ready_mode = 0, stall_phase = 0, stall_left = 0;
  bit gap_mode = 0, irdy_low_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dval(input int ds);
    case (ds)
      0: return 1;
      1: return 4;
      2: return 5;
      3: return 10;
      default: return 11;
    endcase
  endfunction

  // Byte source: pops a byte once the previous cycle showed a handshake.
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc && byte_q.size() > 0) begin
        void'(byte_q.pop_front());
        bytes_acc++;
      end
      if (byte_q.size() > 0 && (!gap_mode || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = byte_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
  end

  // Sink ready: always, random, or a single 10-cycle stall after the first output.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (stall_phase == 0 && out_valid) begin
            out_ready = 1'b0; stall_phase = 1; stall_left = 10;
          end else if (stall_phase == 1) begin
            stall_left--;
            if (stall_left == 0) begin out_ready = 1'b1; stall_phase = 2; end
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    bit held = 0;
    int h_c = 0, h_i = 0, ec, ei;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
      end else begin
        if (held) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_coeff", int'(coeff), h_c);
          check("hold_idx", int'(coeff_idx), h_i);
        end
        if (out_valid && out_ready) begin
          if (exp_coeff.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_output: got coeff %0d idx %0d with nothing expected", coeff, coeff_idx);
          end else begin
            ec = exp_coeff.pop_front();
            ei = exp_idx.pop_front();
            check("coeff", int'(coeff), ec);
            check("coeff_idx", int'(coeff_idx), ei);
          end
        end
        held = out_valid && !out_ready;
        h_c = int'(coeff);
        h_i = int'(coeff_idx);
        if (done) begin
          done_cnt++;
          check("done_all_out", exp_coeff.size(), 0);
          check("done_busy", int'(busy), 1);
        end
        if (err) err_cnt++;
        if (stall_phase == 1 && !in_ready) irdy_low_seen = 1;
      end
    end
  end

  task automatic load_poly(input int ds, input int pat);
    int dv, nb, y, pos;
    logic [7:0] bl[$];
    logic [7:0] b;
    dv = dval(ds);
    nb = N * dv / 8;
    byte_q.delete(); exp_coeff.delete(); exp_idx.delete();
    for (int i = 0; i < nb; i++) begin
      case (pat)
        1:       b = (i == 0) ? 8'h01 : 8'h00;
        2:       b = (i == 0) ? 8'hF3 : 8'($urandom);
        3:       b = 8'hFF;
        default: b = 8'($urandom);
      endcase
      bl.push_back(b);
    end
    for (int i = 0; i < N; i++) begin
      y = 0;
      for (int k = 0; k < dv; k++) begin
        pos = i * dv + k;
        b = bl[pos / 8];
        y = y | (int'((b >> (pos % 8)) & 8'd1) << k);
      end
      exp_coeff.push_back((y * 3329 + (1 << (dv - 1))) / (1 << dv));
      exp_idx.push_back(i);
    end
    foreach (bl[i]) byte_q.push_back(bl[i]);
    byte_q.push_back(8'hA5);
    bytes_acc = 0;
  endtask

  task automatic do_start(input logic [2:0] ds);
    @(posedge clk); #1;
    start = 1'b1; d_sel = ds;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_poly(input int ds, input int pat, input bit inject);
    int d0, c;
    load_poly(ds, pat);
    d0 = done_cnt;
    do_start(3'(ds));
    for (c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      start = inject && (c == 40);
      if (start) d_sel = 3'($urandom_range(0, 7));
      if (done_cnt != d0) break;
    end
    start = 1'b0;
    if (c >= 4000) begin
      tests++; fails++;
      $display("FAIL done_timeout: d_sel %0d, %0d outputs still pending", ds, exp_coeff.size());
    end
    repeat (3) @(negedge clk);
    check("bytes_consumed", bytes_acc, N * dval(ds) / 8);
    check("pad_byte_left", byte_q.size(), 1);
    check("done_pulses", done_cnt - d0, 1);
    check("outputs_left", exp_coeff.size(), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_in_ready", int'(in_ready), 0);
    byte_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_coeff"}, int'(coeff), 0);
    check({tag, "_coeff_idx"}, int'(coeff_idx), 0);
`ifdef DECOMP_STALL_CNT_EN
    check({tag, "_stall_cnt"}, int'(stall_cnt), 0);
`endif
  endtask

  initial begin
    int e0, d0, c;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("reset");

    run_poly(0, 1, 0);
    run_poly(1, 2, 0);
    run_poly(3, 3, 0);
    run_poly(4, 3, 0);

    ready_mode = 2; stall_phase = 0; irdy_low_seen = 0;
    run_poly(2, 0, 0);
    check("stall_in_ready_low", int'(irdy_low_seen), 1);
`ifdef DECOMP_STALL_CNT_EN
    check("stall_cnt", int'(stall_cnt), 10);
`endif
    ready_mode = 0;

    e0 = err_cnt;
    do_start(3'd5);
    @(negedge clk);
    check("bad_dsel_err", int'(err), 1);
    check("bad_dsel_busy", int'(busy), 0);
    @(negedge clk);
    check("bad_dsel_err_pulse", int'(err), 0);
    check("bad_dsel_busy2", int'(busy), 0);
    check("bad_dsel_err_count", err_cnt - e0, 1);

    ready_mode = 1; gap_mode = 1;
    repeat (6) run_poly($urandom_range(0, 4), 0, 1);
    check("no_err_in_run", err_cnt - e0, 1);

    ready_mode = 0; gap_mode = 0;
    load_poly(1, 0);
    d0 = done_cnt;
    do_start(3'd1);
    for (c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (out_valid && coeff_idx == 8'd100) break;
    end
    if (c >= 2000) begin
      tests++; fails++;
      $display("FAIL idx100_timeout: coeff_idx %0d", coeff_idx);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    byte_q.delete(); exp_coeff.delete(); exp_idx.delete();
    @(negedge clk);
    check_zero_outputs("midrun_reset");
    repeat (3) @(negedge clk);
    check("midrun_no_done", done_cnt - d0, 0);
    run_poly(1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
